// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package debounce_pkg;

  // Event bundle for consumers that route per-channel pulses together.
  typedef struct packed {
    logic rise;
    logic fall;
    logic rpt;
  } edge_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stable-time counter, registered edge pulses and,
// when DEBOUNCE_MULTI_REPEAT_EN is defined, typematic auto-repeat.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles = 8,
  parameter int unsigned SyncStages     = 2,
  parameter logic        ResetVal       = 1'b0,
  parameter int unsigned RepeatDelay    = 20,
  parameter int unsigned RepeatPeriod   = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic rpt_o
);

  localparam int unsigned     CntW    = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  if (DebounceCycles < 1 || SyncStages < 1 || RepeatDelay < 1 || RepeatPeriod < 1) begin : g_bad
    $error("debounce_chan: counts and stage depth must be at least 1");
  end

  logic [SyncStages-1:0] sync_q;
  logic                  sync;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  out_q, out_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{ResetVal}};
    end else begin
      sync_q[0] <= in_i;
      for (int unsigned i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync = sync_q[SyncStages-1];

  // Any cycle of agreement restarts the count, so the counter cannot wrap.
  always_comb begin
    cnt_d  = '0;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync != out_q) begin
      if (cnt_q == CntLast) begin
        out_d  = sync;
        rise_d = sync;
        fall_d = ~sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      out_q  <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef DEBOUNCE_MULTI_REPEAT_EN
  localparam int unsigned RptW =
      cnt_width((RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod);

  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_last;
  logic            armed_q, armed_d;
  logic            rpt_q, rpt_d;

  // The rise cycle is count 0; armed selects the period once the first pulse is out.
  // Gating on out_d keeps a pulse out of the fall cycle.
  always_comb begin
    rpt_last  = armed_q ? RptW'(RepeatPeriod - 1) : RptW'(RepeatDelay - 1);
    rpt_cnt_d = '0;
    armed_d   = 1'b0;
    rpt_d     = 1'b0;
    if (out_q && out_d) begin
      armed_d = armed_q;
      if (rpt_cnt_q == rpt_last) begin
        rpt_d   = 1'b1;
        armed_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_cnt_q <= '0;
      armed_q   <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      armed_q   <= armed_d;
      rpt_q     <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer for push-buttons and keypad lines; define DEBOUNCE_MULTI_REPEAT_EN
// to enable per-channel auto-repeat pulses on rpt.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH            = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 524288,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        RESET_VAL       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] rpt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .SyncStages    (SYNC_STAGES),
      .ResetVal      (RESET_VAL),
      .RepeatDelay   (REPEAT_DELAY),
      .RepeatPeriod  (REPEAT_PERIOD)
    ) u_chan (
      .clk_i (clk),
      .rst_ni(rst_n),
      .in_i  (in[i]),
      .out_o (out[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i]),
      .rpt_o (rpt[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: table of timed steps plus reset and auto-repeat sequences.
module tb_debounce_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic [3:0] out, rise, fall, rpt;

  int checks;
  int failures;

  debounce_multi #(
    .N_CH           (4),
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES    (2),
    .RESET_VAL      (1'b0),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .out  (out),
    .rise (rise),
    .fall (fall),
    .rpt  (rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] in;
    int         n;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t v(input string nm, input logic [3:0] i, input int n,
                             input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
    vec_t x;
    x.name = nm;
    x.in   = i;
    x.n    = n;
    x.out  = o;
    x.rise = r;
    x.fall = f;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic [3:0] e_out, e_rise, e_fall, e_rpt;
    checks   = 0;
    failures = 0;

    // Inputs change at posedge+1; "n" ticks later the outputs are compared.
    vecs[0]  = v("press_9",   4'b0001, 9, 4'b0000, 4'b0000, 4'b0000);
    vecs[1]  = v("press_10",  4'b0001, 1, 4'b0001, 4'b0001, 4'b0000);
    vecs[2]  = v("press_w",   4'b0001, 1, 4'b0001, 4'b0000, 4'b0000);
    vecs[3]  = v("bnc_hi5",   4'b0011, 5, 4'b0001, 4'b0000, 4'b0000);
    vecs[4]  = v("bnc_lo2",   4'b0001, 2, 4'b0001, 4'b0000, 4'b0000);
    vecs[5]  = v("bnc_hi7",   4'b0011, 7, 4'b0001, 4'b0000, 4'b0000);
    vecs[6]  = v("bnc_hi9",   4'b0011, 2, 4'b0001, 4'b0000, 4'b0000);
    vecs[7]  = v("bnc_rise",  4'b0011, 1, 4'b0011, 4'b0010, 4'b0000);
    vecs[8]  = v("bnc_w",     4'b0011, 1, 4'b0011, 4'b0000, 4'b0000);
    vecs[9]  = v("rel_pr9",   4'b0111, 9, 4'b0011, 4'b0000, 4'b0000);
    vecs[10] = v("rel_pr10",  4'b0111, 1, 4'b0111, 4'b0100, 4'b0000);
    vecs[11] = v("rel_9",     4'b0011, 9, 4'b0111, 4'b0000, 4'b0000);
    vecs[12] = v("rel_10",    4'b0011, 1, 4'b0011, 4'b0000, 4'b0100);
    vecs[13] = v("rel_w",     4'b0011, 1, 4'b0011, 4'b0000, 4'b0000);
    vecs[14] = v("clr_9",     4'b0000, 9, 4'b0011, 4'b0000, 4'b0000);
    vecs[15] = v("clr_10",    4'b0000, 1, 4'b0000, 4'b0000, 4'b0011);
    vecs[16] = v("clr_w",     4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    vecs[17] = v("all_9",     4'b1111, 9, 4'b0000, 4'b0000, 4'b0000);
    vecs[18] = v("all_10",    4'b1111, 1, 4'b1111, 4'b1111, 4'b0000);
    vecs[19] = v("all_w",     4'b1111, 1, 4'b1111, 4'b0000, 4'b0000);

    // Reset state
    rst_n = 1'b0;
    in    = 4'b0000;
    repeat (3) tick();
    chk("rst_out",  out,  4'b0000);
    chk("rst_rise", rise, 4'b0000);
    chk("rst_fall", fall, 4'b0000);
    chk("rst_rpt",  rpt,  4'b0000);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 20; k++) begin
      in = vecs[k].in;
      repeat (vecs[k].n) tick();
      chk($sformatf("%s_out",  vecs[k].name), out,  vecs[k].out);
      chk($sformatf("%s_rise", vecs[k].name), rise, vecs[k].rise);
      chk($sformatf("%s_fall", vecs[k].name), fall, vecs[k].fall);
    end

    // Reset mid-count: ch0 is 5 counts into a pending fall
    in = 4'b1110;
    repeat (7) tick();
    chk("mid_pre_out", out, 4'b1111);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out",  out,  4'b0000);
    chk("mid_rst_rise", rise, 4'b0000);
    chk("mid_rst_fall", fall, 4'b0000);
    in = 4'b0000;
    tick();
    rst_n = 1'b1;
    for (int s = 1; s <= 15; s++) begin
      tick();
      chk($sformatf("mid_post%0d", s), out | rise | fall | rpt, 4'b0000);
    end

    // Reset released while in differs from the reset level
    rst_n = 1'b0;
    in    = 4'b0001;
    repeat (3) tick();
    chk("hi_rst_evt", out | rise | fall, 4'b0000);
    rst_n = 1'b1;
    repeat (9) tick();
    chk("hi_9_out",  out,  4'b0000);
    chk("hi_9_rise", rise, 4'b0000);
    tick();
    chk("hi_10_out",  out,  4'b0001);
    chk("hi_10_rise", rise, 4'b0001);

    // Auto-repeat on ch3: rise at 10, release applied after 35 so fall lands at 45
    rst_n = 1'b0;
    in    = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    in = 4'b1000;
    for (int s = 1; s <= 50; s++) begin
      tick();
      e_out  = (s >= 10 && s < 45) ? 4'b1000 : 4'b0000;
      e_rise = (s == 10) ? 4'b1000 : 4'b0000;
      e_fall = (s == 45) ? 4'b1000 : 4'b0000;
`ifdef DEBOUNCE_MULTI_REPEAT_EN
      e_rpt  = (s == 30 || s == 35 || s == 40) ? 4'b1000 : 4'b0000;
`else
      e_rpt  = 4'b0000;
`endif
      chk($sformatf("rpt_s%0d_out",  s), out,  e_out);
      chk($sformatf("rpt_s%0d_rise", s), rise, e_rise);
      chk($sformatf("rpt_s%0d_fall", s), fall, e_fall);
      chk($sformatf("rpt_s%0d_rpt",  s), rpt,  e_rpt);
      if (s == 35) in = 4'b0000;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
